// File: rtl/fifo_fwft.sv
// Single-clock FIFO with registered or first-word-fall-through read, occupancy
// count, almost-full/almost-empty thresholds, sticky error flags and flush.
module fifo_fwft #(
    parameter int WIDTH     = 32,
    parameter int DEPTH     = 16,
    parameter int FWFT      = 0,
    parameter int AF_THRESH = DEPTH - 2,
    parameter int AE_THRESH = 2
) (
    input  logic                     clock,
    input  logic                     reset_n,
    input  logic                     flush,
    input  logic                     wr_en,
    input  logic [WIDTH-1:0]         wr_data,
    input  logic                     rd_en,
    output logic [WIDTH-1:0]         rd_data,
    output logic                     full,
    output logic                     empty,
    output logic                     almost_full,
    output logic                     almost_empty,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     overflow,
    output logic                     underflow
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];

    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          ovf_q, ovf_d;
    logic          unf_q, unf_d;
    logic          wr_acc, rd_acc;

    // Status is decoded from the count register alone, so no input reaches
    // any status output combinationally.
    always_comb begin
        full         = (count_q == CW'(DEPTH));
        empty        = (count_q == '0);
        almost_full  = (count_q >= CW'(AF_THRESH));
        almost_empty = (count_q <= CW'(AE_THRESH));
        count        = count_q;
        overflow     = ovf_q;
        underflow    = unf_q;
    end

    always_comb begin
        wr_acc   = wr_en && !full && !flush;
        rd_acc   = rd_en && !empty && !flush;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        ovf_d    = ovf_q | (wr_en && full);
        unf_d    = unf_q | (rd_en && empty);
        if (wr_acc) wr_ptr_d = wr_ptr_q + AW'(1);
        if (rd_acc) rd_ptr_d = rd_ptr_q + AW'(1);
        case ({wr_acc, rd_acc})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
            ovf_d    = 1'b0;
            unf_d    = 1'b0;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            ovf_q    <= 1'b0;
            unf_q    <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            ovf_q    <= ovf_d;
            unf_q    <= unf_d;
        end
    end

    // Storage is deliberately left out of reset.
    always_ff @(posedge clock) begin
        if (wr_acc) mem[wr_ptr_q] <= wr_data;
    end

    generate
        if (FWFT != 0) begin : g_fwft
            always_comb rd_data = mem[rd_ptr_q];
        end else begin : g_reg
            logic [WIDTH-1:0] rd_data_q;
            always_ff @(posedge clock or negedge reset_n) begin
                if (!reset_n)    rd_data_q <= '0;
                else if (rd_acc) rd_data_q <= mem[rd_ptr_q];
            end
            always_comb rd_data = rd_data_q;
        end
    endgenerate
endmodule
